// File: rtl/tff.sv
// rtl/tff.sv - bank of WIDTH toggle flip-flops with load, enable, flip flags; optional TFF_TOGGLE_CNT_EN bit-0 toggle counter
module tff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_t,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qbar,
`ifdef TFF_TOGGLE_CNT_EN
  output logic [CNT_W-1:0] o_toggle_cnt,
`endif
  output logic [WIDTH-1:0] o_flip
);

  // Reject degenerate sizes at elaboration rather than building a zero-width bank.
  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("tff: WIDTH and CNT_W must both be >= 1");
  end

  // State update: reset beats load, load beats toggle; bits never interact.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q    <= RESET_VAL;
      o_flip <= '0;
    end else if (i_load) begin
      o_q    <= i_d;
      o_flip <= '0;
    end else if (i_en) begin
      o_q    <= o_q ^ i_t;
      o_flip <= i_t;
    end else begin
      o_flip <= '0;
    end
  end

  // Complement is purely combinational so it tracks o_q with no extra cycle.
  assign o_qbar = ~o_q;

`ifdef TFF_TOGGLE_CNT_EN
  // Count edges where bit 0 really toggled; a load is not a toggle and leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_toggle_cnt <= '0;
    end else if (!i_load && i_en && i_t[0]) begin
      o_toggle_cnt <= o_toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tff.sv
// tb/tb_tff.sv - scoreboard bench for tff, single-bit and 4-bit instances
module tb_tff;

  logic       clk;
  logic       rst;
  logic       i_en;
  logic       i_load;
  logic [3:0] i_t;
  logic [3:0] i_d;

  logic       q1, qbar1, flip1;
  logic [3:0] q4, qbar4, flip4;
`ifdef TFF_TOGGLE_CNT_EN
  logic [1:0] cnt4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] flip;
    logic [1:0] cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_q;
  logic [1:0] m_cnt;

  tff u1 (
    .clk    (clk),
    .rst    (rst),
    .i_t    (i_t[0]),
    .i_en   (i_en),
    .i_load (i_load),
    .i_d    (i_d[0]),
    .o_q    (q1),
    .o_qbar (qbar1),
`ifdef TFF_TOGGLE_CNT_EN
    .o_toggle_cnt (),
`endif
    .o_flip (flip1)
  );

  tff #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk    (clk),
    .rst    (rst),
    .i_t    (i_t),
    .i_en   (i_en),
    .i_load (i_load),
    .i_d    (i_d),
    .o_q    (q4),
    .o_qbar (qbar4),
`ifdef TFF_TOGGLE_CNT_EN
    .o_toggle_cnt (cnt4),
`endif
    .o_flip (flip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input string name, input logic r, input logic en, input logic ld,
                      input logic [3:0] t, input logic [3:0] d);
    exp_t e;
    rst    = r;
    i_en   = en;
    i_load = ld;
    i_t    = t;
    i_d    = d;
    if (r) begin
      m_q    = 4'b0000;
      m_cnt  = 2'd0;
      e.flip = 4'b0000;
    end else if (ld) begin
      m_q    = d;
      e.flip = 4'b0000;
    end else if (en) begin
      m_q    = m_q ^ t;
      e.flip = t;
      if (t[0]) m_cnt = m_cnt + 2'd1;
    end else begin
      e.flip = 4'b0000;
    end
    e.q    = m_q;
    e.cnt  = m_cnt;
    e.name = name;
    sb.push_back(e);

    @(posedge clk);
    #1;

    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = sb.pop_front();
      check({e.name, "_q1"},     {7'd0, q1},     {7'd0, e.q[0]});
      check({e.name, "_qbar1"},  {7'd0, qbar1},  {7'd0, ~e.q[0]});
      check({e.name, "_flip1"},  {7'd0, flip1},  {7'd0, e.flip[0]});
      check({e.name, "_q4"},     {4'd0, q4},     {4'd0, e.q});
      check({e.name, "_qbar4"},  {4'd0, qbar4},  {4'd0, ~e.q});
      check({e.name, "_flip4"},  {4'd0, flip4},  {4'd0, e.flip});
`ifdef TFF_TOGGLE_CNT_EN
      check({e.name, "_cnt"},    {6'd0, cnt4},   {6'd0, e.cnt});
`endif
    end
  endtask

  initial begin
    rst = 1'b0; i_en = 1'b1; i_load = 1'b0; i_t = '0; i_d = '0;
    m_q = 4'b0000; m_cnt = 2'd0;
    @(posedge clk);
    #1;

    // Reset wins over load and toggle.
    step("reset", 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111);

    // Hold then toggle twice.
    for (int i = 0; i < 2; i++) step("hold", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 2; i++) step("tog",  1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);

    // Counter from zero: 5 toggling edges wrap a 2-bit count.
    step("reset2", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) step("cnt5", 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);

    // Divide-by-2 on every bit.
    for (int i = 0; i < 8; i++) step("div2", 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000);

    // Enable low freezes state even with toggle requested.
    for (int i = 0; i < 3; i++) step("frozen", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);

    // Load beats toggle, and leaves the counter alone.
    step("load", 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1011);
    step("load0", 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0100);

    // Multi-bit independence from zero.
    step("reset3", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    step("mb0101", 1'b0, 1'b1, 1'b0, 4'b0101, 4'b0000);
    step("mb0011", 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0000);
    step("mbrst",  1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);

    // Randomised mix with occasional reset and load.
    for (int i = 0; i < 40; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff.md
Name: tff

Overview:
- Bank of WIDTH toggle (T) flip-flops sharing one clock and one synchronous active-high reset.
- Each bit inverts its stored state on a rising clk edge when its toggle input is high, and holds otherwise.
- Complementary outputs are provided.
- Intended as a generic toggle/divide-by-2 storage element.
- Default WIDTH=1 gives the classic single T flip-flop with ports clk, i_t, o_q, o_qbar.

Parameters:
- WIDTH, 1, number of independent T flip-flops (>=1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into o_q on reset.
- CNT_W, 8, toggle-counter width; used only when TFF_TOGGLE_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state changes occur on its rising edge.
- rst  input  1  synchronous active-high reset.
- i_t  input  WIDTH  per-bit toggle request.
- i_en  input  1  global clock enable; 0 freezes toggling. Tie to 1 for plain TFF use.
- i_load  input  1  synchronous parallel load.
- i_d  input  WIDTH  load data.
- o_q  output  WIDTH  stored state (registered).
- o_qbar  output  WIDTH  bitwise complement of o_q.
- o_flip  output  WIDTH  registered; bit k is 1 for the one cycle after bit k toggled.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled only on the rising clk edge. No asynchronous path.
- Priority at each rising edge: rst > i_load > toggle.
- rst=1: o_q <= RESET_VAL; o_flip <= 0. Also clears the counter when the optional feature is present. This holds even if i_load or i_t are high.
- rst=0, i_load=1: o_q <= i_d; o_flip <= 0. i_t and i_en are ignored.
- rst=0, i_load=0, i_en=1: o_q <= o_q ^ i_t; o_flip <= i_t.
- rst=0, i_load=0, i_en=0: o_q holds; o_flip <= 0.
- o_qbar = ~o_q combinationally at all times, including during and after reset. It is never equal to o_q.
- Latency: a toggle request sampled at edge N is visible on o_q immediately after edge N. No extra pipeline stages.
- i_t held high continuously with i_en=1: the bit toggles every cycle (clk/2 square wave).
- i_t held low: the bit holds indefinitely.
- i_t changes between edges have no effect. Only the value at the rising edge matters.
- Before the first reset, o_q is undefined (X in simulation). The bench must reset first.
- Reset asserted mid-sequence takes effect at the next rising edge and discards any toggle at that edge.
- Bits are fully independent. There are no inter-bit carries.

Optional Feature:
- Macro: TFF_TOGGLE_CNT_EN.
- Defined: adds output o_toggle_cnt [CNT_W-1:0].
  - Counts rising edges at which bit 0 actually toggled (rst=0, i_load=0, i_en=1, i_t[0]=1).
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared to 0 by rst. Unchanged by i_load.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 1 edge with i_t=1, i_load=1 -> o_q=RESET_VAL (0), o_qbar=1, o_flip=0.
- Hold/toggle, WIDTH=1, i_en=1:
  - i_t=0 for 2 edges after reset -> o_q stays 0.
  - Then i_t=1 for 2 edges -> o_q 1 then 0; o_qbar inverse; o_flip=1 on both cycles.
- Divide-by-2: i_t=1 for 8 edges -> o_q alternates 1,0,1,0,...; o_qbar always ~o_q.
- Enable and load:
  - i_en=0, i_t=1 for 3 edges -> o_q frozen.
  - i_load=1, i_d=1 with i_t=1 -> o_q=1 (load wins), o_flip=0.
- Multi-bit, WIDTH=4, from 4'b0000: i_t=4'b0101 -> 4'b0101; then i_t=4'b0011 -> 4'b0110; then rst with i_t=4'b1111 -> 4'b0000.
- With TFF_TOGGLE_CNT_EN, CNT_W=2: 5 toggling edges on bit 0 -> o_toggle_cnt 1,2,3,0,1; rst -> 0.
